// File: rtl/btb_pkg.sv
// Shared constants, counter encodings and FSM states for the branch target buffer controller.
package btb_pkg;

    localparam int SET_LSB = 2;
    localparam int TAG_LSB = 5;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_INV  = 2'd2
    } state_t;

    // 2-bit saturating branch counter step
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == ST) ? ST : cur + 2'd1;
        end
        return (cur == SNT) ? SNT : cur - 2'd1;
    endfunction

endpackage

// File: rtl/btb_ctrl_if.sv
// Fetch lookup, execute update, invalidate and storage array ports of the BTB controller.
interface btb_ctrl_if #(
    parameter int TAGW = 27,
    parameter int SETW = 3
);
    logic            lk_valid;
    logic [31:0]     lk_pc;
    logic            lk_ready;
    logic            lk_hit;
    logic            lk_taken;
    logic [31:0]     lk_target;

    logic            upd_valid;
    logic            upd_ready;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic [31:0]     upd_target;

    logic            inv_req;
    logic            inv_busy;

    logic [SETW-1:0] bf_rd_set;
    logic            bf_rd_valid0;
    logic            bf_rd_valid1;
    logic [TAGW-1:0] bf_rd_tag0;
    logic [TAGW-1:0] bf_rd_tag1;
    logic [31:0]     bf_rd_target0;
    logic [31:0]     bf_rd_target1;
    logic [1:0]      bf_rd_state0;
    logic [1:0]      bf_rd_state1;
    logic            bf_rd_lru;

    logic            bf_wr_en;
    logic [SETW-1:0] bf_wr_set;
    logic            bf_wr_way;
    logic            bf_wr_valid;
    logic [TAGW-1:0] bf_wr_tag;
    logic [31:0]     bf_wr_target;
    logic [1:0]      bf_wr_state;
    logic            bf_wr_lru_en;
    logic            bf_wr_lru_val;

    modport master (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, inv_req,
        input  bf_rd_valid0, bf_rd_valid1, bf_rd_tag0, bf_rd_tag1,
        input  bf_rd_target0, bf_rd_target1, bf_rd_state0, bf_rd_state1, bf_rd_lru,
        output lk_ready, lk_hit, lk_taken, lk_target, upd_ready, inv_busy, bf_rd_set,
        output bf_wr_en, bf_wr_set, bf_wr_way, bf_wr_valid, bf_wr_tag, bf_wr_target,
        output bf_wr_state, bf_wr_lru_en, bf_wr_lru_val
    );

    modport slave (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, inv_req,
        output bf_rd_valid0, bf_rd_valid1, bf_rd_tag0, bf_rd_tag1,
        output bf_rd_target0, bf_rd_target1, bf_rd_state0, bf_rd_state1, bf_rd_lru,
        input  lk_ready, lk_hit, lk_taken, lk_target, upd_ready, inv_busy, bf_rd_set,
        input  bf_wr_en, bf_wr_set, bf_wr_way, bf_wr_valid, bf_wr_tag, bf_wr_target,
        input  bf_wr_state, bf_wr_lru_en, bf_wr_lru_val
    );

endinterface

// File: rtl/btb_way_match.sv
// Purpose: 2-way tag compare with hit-way and replacement-victim select.
// Latency: combinational.
// Backpressure: none.
module btb_way_match #(
    parameter int TAGW = 27
) (
    input  logic            valid0,
    input  logic            valid1,
    input  logic [TAGW-1:0] tag0,
    input  logic [TAGW-1:0] tag1,
    input  logic [TAGW-1:0] cmp_tag,
    input  logic            lru,
    output logic            hit,
    output logic            hit_way,
    output logic            victim
);

    logic hit0;
    logic hit1;

    always_comb begin
        hit0    = valid0 && (tag0 == cmp_tag);
        hit1    = valid1 && (tag1 == cmp_tag);
        hit     = hit0 || hit1;
        // way0 wins when both ways match
        hit_way = !hit0;
        victim  = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
    end

endmodule

// File: rtl/btb_ctrl.sv
// Purpose: BTB array port arbiter: fetch lookups, read-modify-write updates, invalidate-all sweep.
// Latency: lookup same cycle; update 1 cycle after accept; sweep 16 cycles.
// Backpressure: lk_ready/upd_ready drop during update and sweep; lookups are not queued.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int         SETS        = 8,
    parameter int         TAGW        = 27,
    parameter logic [1:0] ALLOC_STATE = WT,
    parameter logic [1:0] INV_STATE   = WNT
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_ctrl_if.master  bus
);

    localparam int SETW = $clog2(SETS);

    typedef struct packed {
        logic [SETW-1:0] set;
        logic [TAGW-1:0] tag;
        logic            taken;
        logic [31:0]     target;
    } upd_t;

    state_t          state_q, state_d;
    upd_t            upd_q;
    logic [3:0]      sweep_q;
    logic            upd_accept;

    logic [SETW-1:0] lk_set;
    logic [TAGW-1:0] lk_tag;
    logic [SETW-1:0] rd_set;
    logic [TAGW-1:0] cmp_tag;
    logic            in_upd;
    logic            hit;
    logic            hit_way;
    logic            victim;
    logic [1:0]      hit_state;
    logic [31:0]     hit_target;
    logic            unused_pc_bits;

    assign lk_set         = bus.lk_pc[SET_LSB +: SETW];
    assign lk_tag         = bus.lk_pc[TAG_LSB +: TAGW];
    assign unused_pc_bits = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

    // The single read port follows the buffered update while in UPD, fetch otherwise
    assign in_upd        = (state_q == S_UPD);
    assign rd_set        = in_upd ? upd_q.set : lk_set;
    assign cmp_tag       = in_upd ? upd_q.tag : lk_tag;
    assign bus.bf_rd_set = rd_set;

    btb_way_match #(.TAGW(TAGW)) u_match (
        .valid0  (bus.bf_rd_valid0),
        .valid1  (bus.bf_rd_valid1),
        .tag0    (bus.bf_rd_tag0),
        .tag1    (bus.bf_rd_tag1),
        .cmp_tag (cmp_tag),
        .lru     (bus.bf_rd_lru),
        .hit     (hit),
        .hit_way (hit_way),
        .victim  (victim)
    );

    assign hit_state  = hit_way ? bus.bf_rd_state1  : bus.bf_rd_state0;
    assign hit_target = hit_way ? bus.bf_rd_target1 : bus.bf_rd_target0;

    always_comb begin
        state_d           = state_q;
        upd_accept        = 1'b0;
        bus.lk_ready      = 1'b0;
        bus.lk_hit        = 1'b0;
        bus.lk_taken      = 1'b0;
        bus.lk_target     = '0;
        bus.upd_ready     = 1'b0;
        bus.inv_busy      = 1'b0;
        bus.bf_wr_en      = 1'b0;
        bus.bf_wr_set     = rd_set;
        bus.bf_wr_way     = 1'b0;
        bus.bf_wr_valid   = 1'b0;
        bus.bf_wr_tag     = '0;
        bus.bf_wr_target  = '0;
        bus.bf_wr_state   = SNT;
        bus.bf_wr_lru_en  = 1'b0;
        bus.bf_wr_lru_val = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.lk_ready  = 1'b1;
                bus.upd_ready = !bus.inv_req;
                bus.lk_hit    = bus.lk_valid && hit;
                bus.lk_taken  = bus.lk_hit && hit_state[1];
                bus.lk_target = bus.lk_hit ? hit_target : 32'd0;
                if (bus.lk_hit) begin
                    bus.bf_wr_lru_en  = 1'b1;
                    bus.bf_wr_lru_val = ~hit_way;
                end
                if (bus.inv_req) begin
                    state_d = S_INV;
                end else if (bus.upd_valid) begin
                    upd_accept = 1'b1;
                    state_d    = S_UPD;
                end
            end
            S_UPD: begin
                if (hit) begin
                    bus.bf_wr_en      = 1'b1;
                    bus.bf_wr_way     = hit_way;
                    bus.bf_wr_valid   = 1'b1;
                    bus.bf_wr_tag     = upd_q.tag;
                    bus.bf_wr_target  = upd_q.taken ? upd_q.target : hit_target;
                    bus.bf_wr_state   = ctr_next(hit_state, upd_q.taken);
                    bus.bf_wr_lru_en  = 1'b1;
                    bus.bf_wr_lru_val = ~hit_way;
                end else if (upd_q.taken) begin
                    bus.bf_wr_en      = 1'b1;
                    bus.bf_wr_way     = victim;
                    bus.bf_wr_valid   = 1'b1;
                    bus.bf_wr_tag     = upd_q.tag;
                    bus.bf_wr_target  = upd_q.target;
                    bus.bf_wr_state   = ALLOC_STATE;
                    bus.bf_wr_lru_en  = 1'b1;
                    bus.bf_wr_lru_val = ~victim;
                end
                state_d = bus.inv_req ? S_INV : S_IDLE;
            end
            S_INV: begin
                bus.inv_busy      = 1'b1;
                bus.bf_wr_en      = 1'b1;
                bus.bf_wr_set     = sweep_q[3:1];
                bus.bf_wr_way     = sweep_q[0];
                bus.bf_wr_state   = INV_STATE;
                bus.bf_wr_lru_en  = sweep_q[0];
                state_d           = (sweep_q == 4'd15) ? S_IDLE : S_INV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            upd_q   <= '0;
            sweep_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (upd_accept) begin
                upd_q <= '{set:    bus.upd_pc[SET_LSB +: SETW],
                           tag:    bus.upd_pc[TAG_LSB +: TAGW],
                           taken:  bus.upd_taken,
                           target: bus.upd_target};
            end
            // Wraps back to 0 after the last sweep cycle, ready for the next sweep
            if (state_q == S_INV) begin
                sweep_q <= sweep_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: array storage, behavioural BTB model and per-cycle compare.
module tb_btb_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    btb_ctrl_if #(.TAGW(27), .SETW(3)) bus ();

    btb_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    // Storage array: combinational read, write at the rising edge
    logic        s_v   [8][2];
    logic [26:0] s_tag [8][2];
    logic [31:0] s_tgt [8][2];
    logic [1:0]  s_st  [8][2];
    logic        s_lru [8];

    assign bus.bf_rd_valid0  = s_v[bus.bf_rd_set][0];
    assign bus.bf_rd_valid1  = s_v[bus.bf_rd_set][1];
    assign bus.bf_rd_tag0    = s_tag[bus.bf_rd_set][0];
    assign bus.bf_rd_tag1    = s_tag[bus.bf_rd_set][1];
    assign bus.bf_rd_target0 = s_tgt[bus.bf_rd_set][0];
    assign bus.bf_rd_target1 = s_tgt[bus.bf_rd_set][1];
    assign bus.bf_rd_state0  = s_st[bus.bf_rd_set][0];
    assign bus.bf_rd_state1  = s_st[bus.bf_rd_set][1];
    assign bus.bf_rd_lru     = s_lru[bus.bf_rd_set];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int s = 0; s < 8; s++) begin
                s_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_v[s][w] <= 1'b0; s_tag[s][w] <= '0; s_tgt[s][w] <= '0; s_st[s][w] <= 2'd0;
                end
            end
        end else begin
            if (bus.bf_wr_en) begin
                s_v[bus.bf_wr_set][bus.bf_wr_way]   <= bus.bf_wr_valid;
                s_tag[bus.bf_wr_set][bus.bf_wr_way] <= bus.bf_wr_tag;
                s_tgt[bus.bf_wr_set][bus.bf_wr_way] <= bus.bf_wr_target;
                s_st[bus.bf_wr_set][bus.bf_wr_way]  <= bus.bf_wr_state;
            end
            if (bus.bf_wr_lru_en) s_lru[bus.bf_wr_set] <= bus.bf_wr_lru_val;
        end
    end

    // Behavioural model: BTB contents as plain arrays of entries plus an operating mode
    localparam int M_IDLE = 0, M_UPD = 1, M_INV = 2;
    int          mmode;
    int          mcnt;
    bit          mv   [8][2];
    logic [26:0] mt   [8][2];
    logic [31:0] mtg  [8][2];
    int          mc   [8][2];
    int          ml   [8];
    logic [31:0] b_pc, b_tgt;
    bit          b_tk;

    function automatic int mfind(input logic [31:0] pc);
        for (int w = 0; w < 2; w++)
            if (mv[pc[4:2]][w] && mt[pc[4:2]][w] == pc[31:5]) return w;
        return -1;
    endfunction

    task automatic mclear();
        for (int s = 0; s < 8; s++) begin
            ml[s] = 0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0; mt[s][w] = '0; mtg[s][w] = '0; mc[s][w] = 0;
            end
        end
    endtask

    task automatic mapply_update();
        int s, w, v;
        s = int'(b_pc[4:2]);
        w = mfind(b_pc);
        if (w >= 0) begin
            if (b_tk) begin
                mc[s][w] = (mc[s][w] == 3) ? 3 : mc[s][w] + 1;
                mtg[s][w] = b_tgt;
            end else begin
                mc[s][w] = (mc[s][w] == 0) ? 0 : mc[s][w] - 1;
            end
            ml[s] = 1 - w;
        end else if (b_tk) begin
            v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : ml[s]);
            mv[s][v] = 1; mt[s][v] = b_pc[31:5]; mtg[s][v] = b_tgt; mc[s][v] = 2;
            ml[s] = 1 - v;
        end
    endtask

    initial begin
        mmode = M_IDLE;
        mcnt  = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mmode = M_IDLE;
                mcnt  = 0;
                if (mem_clr) mclear();
            end else if (mmode == M_IDLE) begin
                if (bus.lk_valid && mfind(bus.lk_pc) >= 0) ml[bus.lk_pc[4:2]] = 1 - mfind(bus.lk_pc);
                if (bus.inv_req) begin
                    mmode = M_INV; mcnt = 0;
                end else if (bus.upd_valid) begin
                    b_pc = bus.upd_pc; b_tk = bus.upd_taken; b_tgt = bus.upd_target;
                    mmode = M_UPD;
                end
            end else if (mmode == M_UPD) begin
                mapply_update();
                mmode = bus.inv_req ? M_INV : M_IDLE;
                mcnt  = 0;
            end else begin
                mv[mcnt/2][mcnt%2] = 0; mt[mcnt/2][mcnt%2] = '0;
                mtg[mcnt/2][mcnt%2] = '0; mc[mcnt/2][mcnt%2] = 1;
                if (mcnt % 2 == 1) ml[mcnt/2] = 0;
                if (mcnt == 15) mmode = M_IDLE;
                else mcnt = mcnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every handshake/lookup output against the model
    always @(negedge clk) begin : cmp
        int  w;
        bit  idle;
        if (rst_n && !mem_clr) begin
            idle = (mmode == M_IDLE);
            w = (idle && bus.lk_valid) ? mfind(bus.lk_pc) : -1;
            chk("cyc_lk_ready", {31'd0, bus.lk_ready}, {31'd0, idle});
            chk("cyc_upd_ready", {31'd0, bus.upd_ready}, {31'd0, idle && !bus.inv_req});
            chk("cyc_inv_busy", {31'd0, bus.inv_busy}, {31'd0, mmode == M_INV});
            chk("cyc_lk_hit", {31'd0, bus.lk_hit}, {31'd0, w >= 0});
            chk("cyc_lk_taken", {31'd0, bus.lk_taken}, (w >= 0 && mc[bus.lk_pc[4:2]][w] >= 2) ? 32'd1 : 32'd0);
            chk("cyc_lk_target", bus.lk_target, (w >= 0) ? mtg[bus.lk_pc[4:2]][w] : 32'd0);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input bit hit, input bit tk, input logic [31:0] tgt, input string nm);
        sync();
        bus.lk_valid = 1'b1;
        bus.lk_pc    = pc;
        @(negedge clk);
        chk({nm, "_ready"},  {31'd0, bus.lk_ready}, 32'd1);
        chk({nm, "_hit"},    {31'd0, bus.lk_hit},   {31'd0, hit});
        chk({nm, "_taken"},  {31'd0, bus.lk_taken}, {31'd0, tk});
        chk({nm, "_target"}, bus.lk_target, tgt);
        sync();
        bus.lk_valid = 1'b0;
    endtask

    // Returns one step into the UPD cycle
    task automatic update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        bit ok;
        sync();
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.upd_ready) begin ok = 1'b1; break; end
        end
        chk("upd_accept", {31'd0, ok}, 32'd1);
        sync();
        bus.upd_valid = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0; mem_clr = 1'b1;
        bus.lk_valid = 0; bus.lk_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0;
        bus.upd_taken = 0; bus.upd_target = '0; bus.inv_req = 0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        #1;
        chk("rst_lk_ready",  {31'd0, bus.lk_ready},     32'd1);
        chk("rst_upd_ready", {31'd0, bus.upd_ready},    32'd1);
        chk("rst_inv_busy",  {31'd0, bus.inv_busy},     32'd0);
        chk("rst_wr_en",     {31'd0, bus.bf_wr_en},     32'd0);
        chk("rst_lru_en",    {31'd0, bus.bf_wr_lru_en}, 32'd0);
        sync();
        rst_n = 1'b1;

        lookup(32'h1004, 0, 0, 32'h0, "cold");
        update(32'h1004, 1, 32'h2000);
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h1004;
        @(negedge clk);
        chk("upd_lk_ready", {31'd0, bus.lk_ready}, 32'd0);
        chk("upd_lk_hit",   {31'd0, bus.lk_hit},   32'd0);
        sync();
        bus.lk_valid = 1'b0;
        lookup(32'h1004, 1, 1, 32'h2000, "alloc");

        update(32'h1004, 0, 32'h0);
        update(32'h1004, 0, 32'h0);
        lookup(32'h1004, 1, 0, 32'h2000, "nt2");
        update(32'h1004, 0, 32'h0);
        lookup(32'h1004, 1, 0, 32'h2000, "nt_floor");
        update(32'h1004, 1, 32'h2000);
        lookup(32'h1004, 1, 0, 32'h2000, "t_one");
        update(32'h1004, 1, 32'h2000);
        update(32'h1004, 1, 32'h2400);
        update(32'h1004, 1, 32'h2400);
        update(32'h1004, 0, 32'h0);
        lookup(32'h1004, 1, 1, 32'h2400, "sat_top");

        update(32'h2004, 1, 32'h3000);
        lookup(32'h1004, 1, 1, 32'h2400, "fill_w0");
        update(32'h3004, 1, 32'h4000);
        lookup(32'h1004, 1, 1, 32'h2400, "keep_w0");
        lookup(32'h2004, 0, 0, 32'h0, "evicted");
        lookup(32'h3004, 1, 1, 32'h4000, "new_w1");
        update(32'h5008, 0, 32'h0);
        lookup(32'h5008, 0, 0, 32'h0, "nt_miss");
        update(32'h100C, 1, 32'h7777_0000);
        lookup(32'h100C, 1, 1, 32'h7777_0000, "set3");

        // Invalidate requested while an update is in flight
        update(32'h0010, 1, 32'h9000);
        bus.inv_req = 1'b1;
        sync();
        bus.inv_req = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.inv_busy) n++;
            else break;
        end
        chk("sweep_len", n, 32'd16);
        for (int s = 0; s < 8; s++) begin
            chk("sweep_lru", {31'd0, s_lru[s]}, 32'd0);
            for (int w = 0; w < 2; w++) begin
                chk("sweep_valid", {31'd0, s_v[s][w]}, 32'd0);
                chk("sweep_state", {30'd0, s_st[s][w]}, 32'd1);
            end
        end
        lookup(32'h1004, 0, 0, 32'h0, "inv_a");
        lookup(32'h3004, 0, 0, 32'h0, "inv_b");
        lookup(32'h100C, 0, 0, 32'h0, "inv_c");
        lookup(32'h0010, 0, 0, 32'h0, "inv_d");

        // Reset in the middle of a sweep, at sweep cycle 7
        update(32'h100C, 1, 32'h7000);
        update(32'h200C, 1, 32'h7100);
        update(32'h1014, 1, 32'h7200);
        sync();
        bus.inv_req = 1'b1;
        sync();
        bus.inv_req = 1'b0;
        chk("sweep_start_busy", {31'd0, bus.inv_busy}, 32'd1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_inv_busy",  {31'd0, bus.inv_busy},  32'd0);
        chk("midrst_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
        chk("midrst_lk_ready",  {31'd0, bus.lk_ready},  32'd1);
        sync();
        rst_n = 1'b1;
        update(32'h1004, 1, 32'h5550);
        lookup(32'h1004, 1, 1, 32'h5550, "post_rst");
        lookup(32'h100C, 0, 0, 32'h0, "swept_w0");
        lookup(32'h200C, 1, 1, 32'h7100, "kept_w1");
        lookup(32'h1014, 1, 1, 32'h7200, "kept_set5");

        repeat (2) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Controller and port arbiter for the 2-way, 8-set branch target buffer storage arrays.
- Serves fetch-stage lookups on the single array read port.
- Sequences execute-stage resolution updates as read-modify-write: hit or allocate, 2-bit counter update, LRU update.
- Runs a multi-cycle invalidate-all sweep. Sits between fetch/execute and the storage block; drives every storage read/write port.

Parameters:
SETS, 8, number of sets (set index = pc[4:2])
TAGW, 27, tag width (tag = pc[31:5])
ALLOC_STATE, 2'b10, counter value written on a new allocation (weakly taken)
INV_STATE, 2'b01, counter value written by the invalidate sweep (weakly not taken)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lk_valid  in  1  fetch lookup request
lk_pc  in  32  fetch PC
lk_ready  out  1  lookup granted this cycle
lk_hit  out  1  granted lookup hit a valid matching way
lk_taken  out  1  predict taken (lk_hit && state[1])
lk_target  out  32  predicted target; 0 when !lk_hit
upd_valid  in  1  branch resolution update request
upd_ready  out  1  update accepted on upd_valid && upd_ready
upd_pc  in  32  resolved branch PC
upd_taken  in  1  actual outcome
upd_target  in  32  actual target
inv_req  in  1  request invalidate-all (level, sampled in IDLE)
inv_busy  out  1  sweep in progress
bf_rd_set  out  3  storage read set
bf_rd_valid0/1  in  1  way valid
bf_rd_tag0/1  in  TAGW  way tag
bf_rd_target0/1  in  32  way target
bf_rd_state0/1  in  2  way counter
bf_rd_lru  in  1  LRU bit of read set (= way to replace next)
bf_wr_en  out  1  storage way write
bf_wr_set  out  3  write set
bf_wr_way  out  1  write way
bf_wr_valid  out  1  valid to write
bf_wr_tag  out  TAGW  tag to write
bf_wr_target  out  32  target to write
bf_wr_state  out  2  counter to write
bf_wr_lru_en  out  1  LRU write enable
bf_wr_lru_val  out  1  LRU value

Behaviour:
- Storage reads are combinational. Storage writes land at the next rising edge.
- FSM states: IDLE, UPD, INV.
  - Reset → IDLE.
  - Update buffer (pc, taken, target) cleared; sweep counter cleared.
  - Output values at reset: lk_ready=1, upd_ready=1, inv_busy=0, bf_wr_en=0, bf_wr_lru_en=0.
- IDLE:
  - lk_ready=1.
  - bf_rd_set=lk_pc[4:2].
  - Hit per way: valid && tag==lk_pc[31:5]. Both ways hit → way0 wins.
  - Lookup results are same-cycle (zero latency).
  - On lk_valid && hit: bf_wr_lru_en=1, bf_wr_lru_val=~hit_way.
- IDLE, update accept and priority:
  - upd_ready = (state==IDLE) && !inv_req.
  - On accept: capture update into the buffer; next state is UPD.
  - inv_req high in IDLE → INV. inv_req has priority over a same-cycle update.
- UPD (exactly 1 cycle):
  - lk_ready=0, lk_hit=0, upd_ready=0.
  - bf_rd_set = buffered set; hit computed against the buffered tag.
  - Hit:
    - Write the same way with valid=1, tag unchanged.
    - Counter saturating: +1 if taken (max 3), −1 if not (min 0).
    - Target = upd_target if taken, else the stored target.
    - lru_val = ~way.
  - Miss and taken → allocate:
    - Victim = way0 if invalid, else way1 if invalid, else bf_rd_lru.
    - Write valid=1, tag, upd_target, ALLOC_STATE; lru_val = ~victim.
  - Miss and not-taken: no write.
  - After UPD → IDLE, or → INV if inv_req is high.
- INV (16 cycles):
  - 4-bit counter c from 0 to 15; set=c[3:1], way=c[0].
  - Each cycle writes valid=0, tag=0, target=0, state=INV_STATE.
  - bf_wr_lru_en=1 with value 0 when c[0]==1.
  - inv_busy=1; lk_ready=0; upd_ready=0.
  - After c==15 → IDLE. inv_req still high at that point starts a new sweep next IDLE cycle.
- lk_valid during UPD/INV is ignored, not queued. Fetch must hold the request or retry.
- Reset asserted mid-UPD or mid-INV: immediately IDLE, buffered update dropped, partial sweep abandoned.
- All widths exact. No arithmetic beyond the 2-bit saturating counter and 4-bit sweep counter.

Decomposition:
- Shared package btb_pkg holds:
  - set/tag slice constants (SET_LSB=2, TAG_LSB=5);
  - counter encodings SNT=0, WNT=1, WT=2, ST=3;
  - the FSM state enum.
- One natural sub-module: btb_way_match, the combinational 2-way tag compare, hit-way select and victim select. It is reused for both the lookup and update paths.

Test Plan:
- After reset, lookup pc=0x0000_1004 → lk_ready=1, lk_hit=0, lk_target=0.
- Update pc=0x0000_1004 taken target=0x0000_2000; next-cycle lookup in UPD sees lk_ready=0; following lookup → lk_hit=1, lk_taken=1 (state 2), lk_target=0x2000.
- Two not-taken updates to that PC → state 2→1→0, lookup lk_hit=1, lk_taken=0. Further not-taken leaves state 0. Three taken updates saturate at 3.
- Fill set 1 with pc 0x1004 (way0) and 0x2004 (way1), then look up 0x1004. Taken update for 0x3004 must evict way1 (lru=1); 0x1004 is still a hit.
- inv_req during UPD: update completes, then inv_busy=1 for exactly 16 cycles. Every entry is invalid; all lookups miss.
- rst_n low at sweep cycle 7 → inv_busy=0 and upd_ready=1 immediately; a subsequent update completes normally.
